etapa_mem: RTL and testbench

//  MEM stage, consumer of the EXE stage outputs. Holds the EX/MEM pipeline latch and a word-addressed data memory.

---
 rtl/etapa_mem.sv | 191 +++++++++++++++++++
 tb/tb_etapa_mem.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/etapa_mem.sv
// etapa_mem: MEM pipeline stage. Holds the EX/MEM latch and a word-addressed
// data memory with configurable access latency, stalls upstream while an
// access is in flight, resolves branches and drives the MEM/WB register.
//
// state  | meaning
// LIBRE  | latch contents complete this cycle; MEM/WB loads from the latch
// ESPERA | memory access in flight; upstream held, MEM/WB receives bubbles
module etapa_mem #(
    parameter int ADDR_BITS   = 8,
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] resultado_alu_EX,
    input  logic [31:0] dr2_forward_EX,
    input  logic [4:0]  registro_destino_EX,
    input  logic        branch_habilitado_EX,
    input  logic [31:0] branch_target_EX,
    input  logic        mem_read_EX,
    input  logic        mem_write_EX,
    input  logic        reg_write_EX,
    input  logic        mem_to_reg_EX,
    input  logic        valido_EX,
    input  logic        flush_MEM,
    output logic        stall_MEM,
    output logic        pc_src_MEM,
    output logic [31:0] branch_target_MEM,
    output logic        error_alineacion_MEM,
    output logic [31:0] resultado_alu_WB,
    output logic [31:0] dato_leido_WB,
    output logic [4:0]  registro_destino_WB,
    output logic        reg_write_WB,
    output logic        mem_to_reg_WB,
    output logic        valido_WB
);
    localparam int DEPTH = 1 << ADDR_BITS;
    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic {LIBRE = 1'b0, ESPERA = 1'b1} estado_t;

    estado_t          estado_q, estado_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0] ex_addr_q, ex_dr2_q, ex_tgt_q;
    logic [4:0]  ex_dst_q;
    logic        ex_br_q, ex_mr_q, ex_mw_q, ex_rw_q, ex_m2r_q, ex_valid_q;

    logic [31:0] wb_res_q, wb_res_d, wb_dato_q, wb_dato_d;
    logic [4:0]  wb_dst_q, wb_dst_d;
    logic        wb_rw_q, wb_rw_d, wb_m2r_q, wb_m2r_d, wb_valid_q, wb_valid_d;

    logic [31:0] mem_q [DEPTH];

    logic                 stall;
    logic                 entra_mem_ok;
    logic                 op_mem, err, acceso, we, re;
    logic [ADDR_BITS-1:0] idx;

    assign stall = (estado_q == ESPERA);

    // An incoming op that will occupy MEM for the full latency
    assign entra_mem_ok = valido_EX & ~flush_MEM & (mem_read_EX ^ mem_write_EX)
                          & (resultado_alu_EX[1:0] == 2'b00);

    assign op_mem = ex_valid_q & (ex_mr_q | ex_mw_q);
    assign err    = op_mem & ((ex_addr_q[1:0] != 2'b00) | (ex_mr_q & ex_mw_q));
    assign acceso = op_mem & ~err & (estado_q == LIBRE);
    assign we     = acceso & ex_mw_q;
    assign re     = acceso & ex_mr_q;
    assign idx    = ex_addr_q[ADDR_BITS+1:2];

    // EX/MEM latch: captures whenever MEM is not stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_addr_q  <= '0;
            ex_dr2_q   <= '0;
            ex_tgt_q   <= '0;
            ex_dst_q   <= '0;
            ex_br_q    <= 1'b0;
            ex_mr_q    <= 1'b0;
            ex_mw_q    <= 1'b0;
            ex_rw_q    <= 1'b0;
            ex_m2r_q   <= 1'b0;
            ex_valid_q <= 1'b0;
        end else if (!stall) begin
            ex_addr_q  <= resultado_alu_EX;
            ex_dr2_q   <= dr2_forward_EX;
            ex_tgt_q   <= branch_target_EX;
            ex_dst_q   <= registro_destino_EX;
            ex_br_q    <= branch_habilitado_EX;
            ex_mr_q    <= mem_read_EX;
            ex_mw_q    <= mem_write_EX;
            ex_rw_q    <= reg_write_EX;
            ex_m2r_q   <= mem_to_reg_EX;
            ex_valid_q <= valido_EX & ~flush_MEM;
        end
    end

    // FSM state and latency counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q <= LIBRE;
            cnt_q    <= '0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next state: enter ESPERA at capture of a good mem op, leave when count ends
    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        case (estado_q)
            LIBRE: begin
                if (entra_mem_ok && (MEM_LATENCY > 1)) begin
                    estado_d = ESPERA;
                    cnt_d    = CNT_W'(MEM_LATENCY - 1);
                end
            end
            ESPERA: begin
                if (cnt_q == CNT_W'(1)) begin
                    estado_d = LIBRE;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                estado_d = LIBRE;
                cnt_d    = '0;
            end
        endcase
    end

    // Store lands in the final cycle of the access; reset aborts it
    always_ff @(posedge clk) begin
        if (!reset && we) begin
            mem_q[idx] <= ex_dr2_q;
        end
    end

    // MEM/WB next value: bubble while waiting, otherwise the latched instruction
    always_comb begin
        wb_res_d   = '0;
        wb_dato_d  = '0;
        wb_dst_d   = '0;
        wb_rw_d    = 1'b0;
        wb_m2r_d   = 1'b0;
        wb_valid_d = 1'b0;
        if (estado_q == LIBRE) begin
            wb_res_d   = ex_addr_q;
            wb_dst_d   = ex_dst_q;
            wb_m2r_d   = ex_m2r_q;
            wb_valid_d = ex_valid_q;
            wb_rw_d    = ex_valid_q & ex_rw_q & ~err;
            wb_dato_d  = re ? mem_q[idx] : 32'h0;
        end
    end

    // MEM/WB register
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_res_q   <= '0;
            wb_dato_q  <= '0;
            wb_dst_q   <= '0;
            wb_rw_q    <= 1'b0;
            wb_m2r_q   <= 1'b0;
            wb_valid_q <= 1'b0;
        end else begin
            wb_res_q   <= wb_res_d;
            wb_dato_q  <= wb_dato_d;
            wb_dst_q   <= wb_dst_d;
            wb_rw_q    <= wb_rw_d;
            wb_m2r_q   <= wb_m2r_d;
            wb_valid_q <= wb_valid_d;
        end
    end

    assign stall_MEM            = stall;
    assign pc_src_MEM           = ex_valid_q & ex_br_q;
    assign branch_target_MEM    = ex_tgt_q;
    assign error_alineacion_MEM = err;
    assign resultado_alu_WB     = wb_res_q;
    assign dato_leido_WB        = wb_dato_q;
    assign registro_destino_WB  = wb_dst_q;
    assign reg_write_WB         = wb_rw_q;
    assign mem_to_reg_WB        = wb_m2r_q;
    assign valido_WB            = wb_valid_q;

endmodule

// File: tb/tb_etapa_mem.sv
// Directed testbench for etapa_mem (ADDR_BITS=8, MEM_LATENCY=2).
module tb_etapa_mem;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] resultado_alu_EX, dr2_forward_EX, branch_target_EX;
    logic [4:0]  registro_destino_EX;
    logic        branch_habilitado_EX, mem_read_EX, mem_write_EX;
    logic        reg_write_EX, mem_to_reg_EX, valido_EX, flush_MEM;
    logic        stall_MEM, pc_src_MEM, error_alineacion_MEM;
    logic [31:0] branch_target_MEM, resultado_alu_WB, dato_leido_WB;
    logic [4:0]  registro_destino_WB;
    logic        reg_write_WB, mem_to_reg_WB, valido_WB;

    int total = 0;
    int bad   = 0;

    etapa_mem #(.ADDR_BITS(8), .MEM_LATENCY(2)) dut (
        .clk(clk), .reset(reset),
        .resultado_alu_EX(resultado_alu_EX), .dr2_forward_EX(dr2_forward_EX),
        .registro_destino_EX(registro_destino_EX),
        .branch_habilitado_EX(branch_habilitado_EX), .branch_target_EX(branch_target_EX),
        .mem_read_EX(mem_read_EX), .mem_write_EX(mem_write_EX),
        .reg_write_EX(reg_write_EX), .mem_to_reg_EX(mem_to_reg_EX),
        .valido_EX(valido_EX), .flush_MEM(flush_MEM),
        .stall_MEM(stall_MEM), .pc_src_MEM(pc_src_MEM),
        .branch_target_MEM(branch_target_MEM), .error_alineacion_MEM(error_alineacion_MEM),
        .resultado_alu_WB(resultado_alu_WB), .dato_leido_WB(dato_leido_WB),
        .registro_destino_WB(registro_destino_WB), .reg_write_WB(reg_write_WB),
        .mem_to_reg_WB(mem_to_reg_WB), .valido_WB(valido_WB)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        rw, m2r, mr, mw, vld, fl, br;
        logic [31:0] tgt;
        logic        e_pc, e_err, e_vwb, e_rwwb;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        resultado_alu_EX     = '0;
        dr2_forward_EX       = '0;
        branch_target_EX     = '0;
        registro_destino_EX  = '0;
        branch_habilitado_EX = 1'b0;
        mem_read_EX          = 1'b0;
        mem_write_EX         = 1'b0;
        reg_write_EX         = 1'b0;
        mem_to_reg_EX        = 1'b0;
        valido_EX            = 1'b0;
        flush_MEM            = 1'b0;
    endtask

    // Aligned load/store through the full two-cycle access; caller checks MEM/WB.
    task automatic mem_op(input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [4:0] rd);
        idle();
        resultado_alu_EX    = addr;
        dr2_forward_EX      = data;
        registro_destino_EX = rd;
        mem_write_EX        = wr;
        mem_read_EX         = ~wr;
        reg_write_EX        = ~wr;
        mem_to_reg_EX       = ~wr;
        valido_EX           = 1'b1;
        tick();
        chk("stall_on", {31'b0, stall_MEM}, 32'd1);
        idle();
        tick();
        chk("stall_off", {31'b0, stall_MEM}, 32'd0);
        chk("bubble_valid", {31'b0, valido_WB}, 32'd0);
        chk("bubble_rw", {31'b0, reg_write_WB}, 32'd0);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        //          res           rd  rw m2r mr mw vld fl br tgt           pc err vwb rwwb
        vecs[0] = '{32'h10,       5,  1, 0,  0, 0, 1,  0, 0, 32'h0,        0, 0,  1,  1};
        vecs[1] = '{32'h7,        31, 0, 0,  0, 0, 1,  0, 0, 32'h0,        0, 0,  1,  0};
        vecs[2] = '{32'h0,        0,  0, 0,  0, 0, 1,  0, 1, 32'h00400040, 1, 0,  1,  0};
        vecs[3] = '{32'h99,       3,  1, 0,  0, 0, 1,  1, 0, 32'h0,        0, 0,  0,  0};
        vecs[4] = '{32'h44,       2,  1, 0,  0, 0, 0,  0, 1, 32'h123,      0, 0,  0,  0};
        vecs[5] = '{32'h22,       4,  1, 1,  1, 0, 1,  0, 0, 32'h0,        0, 1,  1,  0};
        vecs[6] = '{32'h21,       0,  0, 0,  0, 1, 1,  0, 0, 32'h0,        0, 1,  1,  0};
        vecs[7] = '{32'h24,       6,  1, 1,  1, 1, 1,  0, 0, 32'h0,        0, 1,  1,  0};
        vecs[8] = '{32'h26,       7,  1, 1,  1, 0, 0,  0, 0, 32'h0,        0, 0,  0,  0};
        vecs[9] = '{32'h2A,       9,  1, 1,  1, 0, 1,  1, 0, 32'h0,        0, 0,  0,  0};

        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_stall", {31'b0, stall_MEM}, 32'd0);
        chk("rst_pc_src", {31'b0, pc_src_MEM}, 32'd0);
        chk("rst_target", branch_target_MEM, 32'd0);
        chk("rst_err", {31'b0, error_alineacion_MEM}, 32'd0);
        chk("rst_valid", {31'b0, valido_WB}, 32'd0);
        chk("rst_res", resultado_alu_WB, 32'd0);
        chk("rst_rw", {31'b0, reg_write_WB}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            idle();
            resultado_alu_EX     = vecs[i].res;
            registro_destino_EX  = vecs[i].rd;
            reg_write_EX         = vecs[i].rw;
            mem_to_reg_EX        = vecs[i].m2r;
            mem_read_EX          = vecs[i].mr;
            mem_write_EX         = vecs[i].mw;
            valido_EX            = vecs[i].vld;
            flush_MEM            = vecs[i].fl;
            branch_habilitado_EX = vecs[i].br;
            branch_target_EX     = vecs[i].tgt;
            tick();
            chk($sformatf("v%0d_pc_src", i), {31'b0, pc_src_MEM}, {31'b0, vecs[i].e_pc});
            chk($sformatf("v%0d_target", i), branch_target_MEM, vecs[i].tgt);
            chk($sformatf("v%0d_err", i), {31'b0, error_alineacion_MEM}, {31'b0, vecs[i].e_err});
            chk($sformatf("v%0d_stall", i), {31'b0, stall_MEM}, 32'd0);
            idle();
            tick();
            chk($sformatf("v%0d_err_pulse", i), {31'b0, error_alineacion_MEM}, 32'd0);
            chk($sformatf("v%0d_valid_wb", i), {31'b0, valido_WB}, {31'b0, vecs[i].e_vwb});
            chk($sformatf("v%0d_rw_wb", i), {31'b0, reg_write_WB}, {31'b0, vecs[i].e_rwwb});
            chk($sformatf("v%0d_res_wb", i), resultado_alu_WB, vecs[i].res);
            chk($sformatf("v%0d_rd_wb", i), {27'b0, registro_destino_WB}, {27'b0, vecs[i].rd});
            chk($sformatf("v%0d_dato_wb", i), dato_leido_WB, 32'd0);
            chk($sformatf("v%0d_stall2", i), {31'b0, stall_MEM}, 32'd0);
        end

        // store then load back
        mem_op(1'b1, 32'h20, 32'hDEADBEEF, 5'd0);
        chk("sw_valid", {31'b0, valido_WB}, 32'd1);
        chk("sw_rw", {31'b0, reg_write_WB}, 32'd0);
        mem_op(1'b0, 32'h20, 32'h0, 5'd8);
        chk("lw_dato", dato_leido_WB, 32'hDEADBEEF);
        chk("lw_m2r", {31'b0, mem_to_reg_WB}, 32'd1);
        chk("lw_rd", {27'b0, registro_destino_WB}, 32'd8);
        chk("lw_rw", {31'b0, reg_write_WB}, 32'd1);
        chk("lw_valid", {31'b0, valido_WB}, 32'd1);
        chk("lw_res", resultado_alu_WB, 32'h20);

        // reset during a stalled store aborts it
        mem_op(1'b1, 32'h40, 32'hAAAA, 5'd0);
        idle();
        resultado_alu_EX = 32'h40;
        dr2_forward_EX   = 32'h1234;
        mem_write_EX     = 1'b1;
        valido_EX        = 1'b1;
        tick();
        chk("rs_stall_on", {31'b0, stall_MEM}, 32'd1);
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rs_stall_off", {31'b0, stall_MEM}, 32'd0);
        chk("rs_valid", {31'b0, valido_WB}, 32'd0);
        chk("rs_res", resultado_alu_WB, 32'd0);
        tick();
        chk("rs_stall_after", {31'b0, stall_MEM}, 32'd0);
        mem_op(1'b0, 32'h40, 32'h0, 5'd1);
        chk("rs_lw_dato", dato_leido_WB, 32'hAAAA);

        // address wraps modulo memory size
        mem_op(1'b1, 32'h400, 32'h55, 5'd0);
        mem_op(1'b0, 32'h000, 32'h0, 5'd2);
        chk("wrap_dato", dato_leido_WB, 32'h55);
        mem_op(1'b0, 32'h20, 32'h0, 5'd3);
        chk("wrap_other", dato_leido_WB, 32'hDEADBEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
